key_event_ctrl: RTL

//  Gesture scheduler behind the debounced-key front end. Consumes the 1-cycle

---
 rtl/key_event_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/key_event_ctrl.sv
// Gesture scheduler for one debounced key.
// Classifies short/double/long/repeat gestures and steps a display-mode register.
module key_event_ctrl #(
    parameter int CLK_FRAC = 50,
    parameter int LONG_MS  = 1000,
    parameter int DCLK_MS  = 250,
    parameter int RPT_MS   = 200,
    parameter int MODE_NUM = 4,
    localparam int MODE_W  = $clog2(MODE_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_key_pos,
    input  logic              i_key_neg,
    output logic              o_short,
    output logic              o_double,
    output logic              o_long,
    output logic              o_repeat,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_busy
);

    localparam int TICK_N = CLK_FRAC * 1000;
    localparam int PW     = (TICK_N > 1) ? $clog2(TICK_N) : 1;
    localparam int MAX_A  = (LONG_MS > DCLK_MS) ? LONG_MS : DCLK_MS;
    localparam int MAX_MS = (MAX_A > RPT_MS) ? MAX_A : RPT_MS;
    localparam int TW     = $clog2(MAX_MS + 1);

    localparam logic [PW-1:0]     PRESC_END = PW'(TICK_N - 1);
    localparam logic [TW-1:0]     LONG_END  = TW'(LONG_MS - 1);
    localparam logic [TW-1:0]     DCLK_END  = TW'(DCLK_MS - 1);
    localparam logic [TW-1:0]     RPT_END   = TW'(RPT_MS - 1);
    localparam logic [TW-1:0]     TIMER_MAX = '1;
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              short_q, short_d;
    logic              double_q, double_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    logic              tick;
    logic              restart;
    logic [MODE_W-1:0] mode_inc;
    logic [MODE_W-1:0] mode_dec;

    // A deadline of N ms fires on the edge N*TICK_N cycles after the
    // restarting edge: the counters read N*TICK_N-1 just before it.
    assign tick     = (presc_q == PRESC_END);
    assign mode_inc = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
    assign mode_dec = (mode_q == '0) ? MODE_LAST : mode_q - 1'b1;

    // Next-state, event and mode decision for the gesture FSM
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        if (!i_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_key_pos && !i_key_neg) state_d = S_PRESS1;
                end
                S_PRESS1: begin
                    if (i_key_neg) begin
                        state_d = S_WAIT2;
                    end else if (tick && timer_q == LONG_END) begin
                        long_d  = 1'b1;
                        mode_d  = '0;
                        state_d = S_HOLD;
                    end
                end
                S_WAIT2: begin
                    if (i_key_pos && !i_key_neg) begin
                        state_d = S_PRESS2;
                    end else if (tick && timer_q == DCLK_END) begin
                        short_d = 1'b1;
                        mode_d  = mode_inc;
                        state_d = S_IDLE;
                    end
                end
                S_PRESS2: begin
                    if (i_key_neg) begin
                        double_d = 1'b1;
                        mode_d   = mode_dec;
                        state_d  = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (i_key_neg) begin
                        state_d = S_IDLE;
                    end else if (tick && timer_q == RPT_END) begin
                        repeat_d = 1'b1;
                        mode_d   = mode_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Timebase restarts on any state change, on each repeat and while idle
    always_comb begin
        restart = (state_d != state_q) || repeat_d || (state_q == S_IDLE);
        presc_d = tick ? '0 : presc_q + 1'b1;
        timer_d = timer_q;
        if (tick && timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        if (restart) begin
            presc_d = '0;
            timer_d = '0;
        end
    end

    // Register state, timebase, mode and the one-shot event pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            timer_q  <= '0;
            mode_q   <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            mode_q   <= mode_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign o_short  = short_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_mode   = mode_q;
    assign o_busy   = (state_q != S_IDLE);

endmodule
